ex_fwd_hazard_ctrl: RTL and testbench

EX_FWD_HAZARD_CTRL -- requirements
Module: ex_fwd_hazard_ctrl

---
 rtl/ex_fwd_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ex_fwd_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_fwd_hazard_ctrl.sv
// ex_fwd_hazard_ctrl
// Forwarding-select and load-use hazard control for a classic 5-stage MIPS
// pipeline. The block keeps its own shadow copy of the EX, MEM and WB stage
// control fields and derives from them:
//   Forward_A / Forward_B : EX operand select (00 id_ex, 01 mem_wb, 10 ex_mem)
//   stall                 : hold PC and IF/ID, bubble into ID/EX (one cycle per load-use)
//   flush_if_id           : zero IF/ID on a taken branch unless a stall is in progress
//   stall_count           : saturating count of stall cycles
// Ports:
//   clk, reset (async, active-low)
//   if_id_instr[31:0]     : ID instruction, rs=[25:21], rt=[20:16]
//   id_reg_write, id_mem_read, id_dest_reg[4:0], id_branch_taken : ID controls
// Parameter CNT_W sets the internal stall counter width (<=16); the counter
// saturates at all-ones of CNT_W and is zero-extended onto stall_count.
module ex_fwd_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_id_instr,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic [4:0]  id_dest_reg,
    input  logic        id_branch_taken,
    output logic [1:0]  Forward_A,
    output logic [1:0]  Forward_B,
    output logic        stall,
    output logic        flush_if_id,
    output logic [15:0] stall_count
);

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_LOAD_STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // MEM has priority over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic       ex_valid,
        input logic [4:0] src,
        input logic       mem_prod,
        input logic [4:0] mem_dest,
        input logic       wb_prod,
        input logic [4:0] wb_dest
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (!ex_valid) begin
            sel = 2'b00;
        end else if (mem_prod && (mem_dest == src)) begin
            sel = 2'b10;
        end else if (wb_prod && (wb_dest == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Stage records
    logic       ex_valid_r, ex_reg_write_r, ex_mem_read_r;
    logic [4:0] ex_dest_r, ex_rs_r, ex_rt_r;
    logic       mem_valid_r, mem_reg_write_r, mem_mem_read_r;
    logic [4:0] mem_dest_r;
    logic       wb_valid_r, wb_reg_write_r, wb_mem_read_r;
    logic [4:0] wb_dest_r;

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    logic       hazard_s, stall_s;
    logic       mem_prod_s, wb_prod_s;
    logic [4:0] id_rs_s, id_rt_s;
    logic       unused_s;

    assign id_rs_s = if_id_instr[25:21];
    assign id_rt_s = if_id_instr[20:16];

    // Opcode/immediate bits and the WB load flag play no part in the decisions.
    assign unused_s = ^{if_id_instr[31:26], if_id_instr[15:0], wb_mem_read_r};

    assign mem_prod_s = mem_valid_r & mem_reg_write_r & (mem_dest_r != 5'd0);
    assign wb_prod_s  = wb_valid_r  & wb_reg_write_r  & (wb_dest_r  != 5'd0);

    // A load in EX whose target is read by the ID instruction; masked in LOAD_STALL
    // so that each load produces exactly one bubble.
    assign hazard_s = (state_r == ST_RUN) && ex_valid_r && ex_mem_read_r &&
                      (ex_dest_r != 5'd0) &&
                      ((ex_dest_r == id_rs_s) || (ex_dest_r == id_rt_s));

    // Stage record advance; EX takes a bubble while stalling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_r      <= 1'b0;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_dest_r       <= 5'd0;
            ex_rs_r         <= 5'd0;
            ex_rt_r         <= 5'd0;
            mem_valid_r     <= 1'b0;
            mem_reg_write_r <= 1'b0;
            mem_mem_read_r  <= 1'b0;
            mem_dest_r      <= 5'd0;
            wb_valid_r      <= 1'b0;
            wb_reg_write_r  <= 1'b0;
            wb_mem_read_r   <= 1'b0;
            wb_dest_r       <= 5'd0;
        end else begin
            wb_valid_r      <= mem_valid_r;
            wb_reg_write_r  <= mem_reg_write_r;
            wb_mem_read_r   <= mem_mem_read_r;
            wb_dest_r       <= mem_dest_r;
            mem_valid_r     <= ex_valid_r;
            mem_reg_write_r <= ex_reg_write_r;
            mem_mem_read_r  <= ex_mem_read_r;
            mem_dest_r      <= ex_dest_r;
            if (stall_s) begin
                ex_valid_r     <= 1'b0;
                ex_reg_write_r <= 1'b0;
                ex_mem_read_r  <= 1'b0;
                ex_dest_r      <= 5'd0;
                ex_rs_r        <= 5'd0;
                ex_rt_r        <= 5'd0;
            end else begin
                ex_valid_r     <= 1'b1;
                ex_reg_write_r <= id_reg_write;
                ex_mem_read_r  <= id_mem_read;
                ex_dest_r      <= id_dest_reg;
                ex_rs_r        <= id_rs_s;
                ex_rt_r        <= id_rt_s;
            end
        end
    end

    // Hazard FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hazard FSM next state and stall output.
    always_comb begin
        state_nxt_s = ST_RUN;
        stall_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                stall_s = hazard_s;
                if (hazard_s) begin
                    state_nxt_s = ST_LOAD_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOAD_STALL: begin
                stall_s     = 1'b0;
                state_nxt_s = ST_RUN;
            end
            default: begin
                stall_s     = 1'b0;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign Forward_A   = fwd_sel(ex_valid_r, ex_rs_r, mem_prod_s, mem_dest_r, wb_prod_s, wb_dest_r);
    assign Forward_B   = fwd_sel(ex_valid_r, ex_rt_r, mem_prod_s, mem_dest_r, wb_prod_s, wb_dest_r);
    assign stall       = stall_s;
    assign flush_if_id = id_branch_taken & ~stall_s;
    assign stall_count = 16'(stall_cnt_r);

endmodule

// File: tb/tb_ex_fwd_hazard_ctrl.sv
module tb_ex_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_id_instr;
    logic        id_reg_write, id_mem_read, id_branch_taken;
    logic [4:0]  id_dest_reg;
    logic [1:0]  Forward_A, Forward_B;
    logic        stall, flush_if_id;
    logic [15:0] stall_count;
    logic [1:0]  s_fa, s_fb;
    logic        s_stall, s_flush;
    logic [15:0] s_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_fwd_hazard_ctrl dut (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_dest_reg(id_dest_reg), .id_branch_taken(id_branch_taken),
        .Forward_A(Forward_A), .Forward_B(Forward_B), .stall(stall),
        .flush_if_id(flush_if_id), .stall_count(stall_count)
    );

    // Narrow-counter instance: reaches saturation within the cycle budget.
    ex_fwd_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_dest_reg(id_dest_reg), .id_branch_taken(id_branch_taken),
        .Forward_A(s_fa), .Forward_B(s_fb), .stall(s_stall),
        .flush_if_id(s_flush), .stall_count(s_count)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v, rw, mr;
        logic [4:0] d, rs, rt;
    } slot_t;

    slot_t pipe [3];        // [0]=EX, [1]=MEM, [2]=WB
    logic  stalled_last;    // previous cycle was the bubble of a load-use
    int    cnt16, cnt4;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        stalled_last = 1'b0;
        cnt16 = 0;
        cnt4  = 0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] r);
        if (!pipe[0].v) return 2'b00;
        if (pipe[1].v && pipe[1].rw && pipe[1].d != 5'd0 && pipe[1].d == r) return 2'b10;
        if (pipe[2].v && pipe[2].rw && pipe[2].d != 5'd0 && pipe[2].d == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        return !stalled_last && pipe[0].v && pipe[0].mr && pipe[0].d != 5'd0 &&
               (pipe[0].d == if_id_instr[25:21] || pipe[0].d == if_id_instr[20:16]);
    endfunction

    task automatic model_edge();
        slot_t nw;
        logic  st;
        st = exp_stall();
        if (st) nw = '0;
        else    nw = '{1'b1, id_reg_write, id_mem_read, id_dest_reg,
                       if_id_instr[25:21], if_id_instr[20:16]};
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nw;
        stalled_last = st;
        if (st && cnt16 < 65535) cnt16++;
        if (st && cnt4 < 15) cnt4++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic tick();
        logic st;
        #1;
        st = exp_stall();
        chk("fwd_a", {30'd0, Forward_A}, {30'd0, exp_fwd(pipe[0].rs)});
        chk("fwd_b", {30'd0, Forward_B}, {30'd0, exp_fwd(pipe[0].rt)});
        chk("stall", {31'd0, stall}, {31'd0, st});
        chk("flush", {31'd0, flush_if_id}, {31'd0, id_branch_taken & ~st});
        chk("count16", {16'd0, stall_count}, cnt16);
        chk("count4", {16'd0, s_count}, cnt4);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic setin(input logic [4:0] rs, input logic [4:0] rt, input logic rw,
                         input logic mr, input logic [4:0] dest, input logic br);
        if_id_instr     = {6'h23, rs, rt, 16'h1234};
        id_reg_write    = rw;
        id_mem_read     = mr;
        id_dest_reg     = dest;
        id_branch_taken = br;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fa"}, {30'd0, Forward_A}, 32'd0);
        chk({tag, "_fb"}, {30'd0, Forward_B}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush_if_id}, 32'd0);
        chk({tag, "_count"}, {16'd0, stall_count}, 32'd0);
        chk({tag, "_count4"}, {16'd0, s_count}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        model_clear();
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();

        // Load-use: lw $4 then add $10,$4,$9 with a taken branch on the stall cycle.
        setin(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0); tick();
        setin(5'd4, 5'd9, 1'b1, 1'b0, 5'd10, 1'b1); #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        chk("lu_flush_masked", {31'd0, flush_if_id}, 32'd0);
        tick();
        chk("lu_count", {16'd0, stall_count}, 32'd1);
        id_branch_taken = 1'b0; #1;
        chk("lu_one_cycle", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_fwd_a_wb", {30'd0, Forward_A}, 32'd1);
        chk("lu_fwd_b", {30'd0, Forward_B}, 32'd0);

        // EX-to-EX forward.
        setin(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0); tick();
        setin(5'd3, 5'd9, 1'b1, 1'b0, 5'd8, 1'b0); tick();
        chk("exex_fa", {30'd0, Forward_A}, 32'd2);
        chk("exex_fb", {30'd0, Forward_B}, 32'd0);

        // WB forward via rt.
        setin(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0); tick();
        setin(5'd11, 5'd12, 1'b1, 1'b0, 5'd10, 1'b0); tick();
        setin(5'd13, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0); tick();
        chk("wb_fb", {30'd0, Forward_B}, 32'd1);
        chk("wb_fa", {30'd0, Forward_A}, 32'd0);

        // Double hit: MEM wins over WB.
        setin(5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0); tick();
        setin(5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0); tick();
        setin(5'd5, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0); tick();
        chk("dbl_fa", {30'd0, Forward_A}, 32'd2);
        chk("dbl_fb", {30'd0, Forward_B}, 32'd2);

        // Writes to $0 never forward.
        setin(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0); tick();
        setin(5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0); tick();
        chk("r0_fa", {30'd0, Forward_A}, 32'd0);

        // Taken branch with no hazard flushes.
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1); #1;
        chk("flush_nohaz", {31'd0, flush_if_id}, 32'd1);
        tick();

        // Reset while stall=1, then release straight into a normal advance.
        setin(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0); tick();
        setin(5'd0, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0); #1;
        chk("rs_pre_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0; #1;
        check_reset_outputs("rst_stall");
        model_clear();
        @(negedge clk);
        setin(5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b0);
        reset = 1'b1;
        tick();
        setin(5'd7, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0); tick();
        chk("rel_first_edge", {30'd0, Forward_A}, 32'd2);

        // Reset while in LOAD_STALL.
        setin(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0); tick();
        setin(5'd6, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0); tick();
        chk("ls_count", {16'd0, stall_count}, 32'd1);
        #1;
        chk("ls_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0; #1;
        check_reset_outputs("rst_ls");
        model_clear();
        @(negedge clk);
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
        tick();

        // Saturation: 20 load-use stalls.
        for (int i = 0; i < 20; i++) begin
            setin(5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b0); tick();
            setin(5'd2, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0); tick();
            tick();
        end
        chk("sat_count16", {16'd0, stall_count}, 32'd20);
        chk("sat_count4", {16'd0, s_count}, 32'd15);

        // Randomized traffic over a small register window.
        for (int i = 0; i < 3000; i++) begin
            logic mr;
            mr = ($urandom_range(0, 3) == 0);
            if_id_instr     = {6'($urandom), 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), 16'($urandom)};
            id_mem_read     = mr;
            id_reg_write    = mr ? 1'b1 : 1'($urandom_range(0, 1));
            id_dest_reg     = 5'($urandom_range(0, 7));
            id_branch_taken = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
